ras_spec_ctrl: RTL and testbench

Speculation controller for the return address stack in the IFU. It accepts call/return hints from the fetch-stage predictor and drives the RAS push/pop/stall controls. Every speculative RAS operation is recorded in an undo log so that a pipeline flush restores the stack exactly. Log entries retire on commit. On flush, a repair FSM replays the inverse operations newest-first, one per cycle.

---
 rtl/ras_spec_ctrl.sv | 140 ++++++++++++++
 tb/tb_ras_spec_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ras_spec_ctrl.sv
// Speculation controller for the return address stack: drives RAS push/pop from
// predictor hints, logs each op, and replays inverse ops newest-first on flush.
`ifndef RAS_DEPTH
`define RAS_DEPTH 16
`endif

module ras_spec_ctrl #(
  parameter int DEPTH     = `RAS_DEPTH,
  parameter int LOG_DEPTH = 8,
  parameter int XLEN      = 32,
  localparam int AW = $clog2(LOG_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            pred_valid,
  input  logic            pred_call,
  input  logic            pred_ret,
  input  logic [XLEN-1:0] pred_ra,
  output logic            pred_ready,
  output logic [XLEN-1:0] pred_target,
  output logic            pred_target_valid,
  input  logic            commit_valid,
  input  logic            flush,
  output logic            busy,
  output logic [CW-1:0]   log_count,
  output logic            ras_push_en,
  output logic [XLEN-1:0] ras_push_data,
  output logic            ras_pop_en,
  output logic            ras_stall,
  input  logic [XLEN-1:0] ras_peek_data,
  input  logic            ras_empty
);

  if (DEPTH < 1 || LOG_DEPTH < 2 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_bad_params
    $error("ras_spec_ctrl: DEPTH >= 1 and LOG_DEPTH a power of 2 >= 2 required");
  end

  localparam logic [1:0] T_NOP  = 2'd0;
  localparam logic [1:0] T_PUSH = 2'd1;
  localparam logic [1:0] T_POP  = 2'd2;
  localparam logic [1:0] T_BOTH = 2'd3;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_REPAIR = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d, undo_idx;
  logic [CW-1:0]   count_q, count_d, count_post;
  logic [1:0]      typ_q [LOG_DEPTH];
  logic [XLEN-1:0] dat_q [LOG_DEPTH];
  logic            idle, accept, commit_ok;
  logic [1:0]      wr_typ;
  logic [XLEN-1:0] wr_dat;

  assign idle              = (state_q == S_IDLE);
  assign undo_idx          = tail_q - AW'(1);
  assign pred_ready        = rst & idle & ~flush & ~stall & (count_q < CW'(LOG_DEPTH));
  assign accept            = pred_valid & pred_ready;
  assign commit_ok         = rst & idle & ~stall & commit_valid & (count_q != '0);
  assign busy              = (state_q == S_REPAIR);
  assign pred_target       = ras_peek_data;
  assign pred_target_valid = ~ras_empty & idle;
  assign log_count         = count_q;
  assign ras_stall         = ~rst | stall;

  // Forward ops on accept; inverse of the newest entry while repairing.
  always_comb begin
    ras_push_en   = 1'b0;
    ras_pop_en    = 1'b0;
    ras_push_data = '0;
    wr_typ        = T_NOP;
    wr_dat        = '0;
    if (accept) begin
      if (pred_call) begin
        ras_push_en   = 1'b1;
        ras_pop_en    = pred_ret;
        ras_push_data = pred_ra;
        wr_dat        = pred_ra;
        wr_typ        = pred_ret ? T_BOTH : T_PUSH;
      end else if (pred_ret && !ras_empty) begin
        ras_pop_en = 1'b1;
        wr_typ     = T_POP;
        wr_dat     = ras_peek_data;
      end
    end else if (rst && !stall && !idle) begin
      case (typ_q[undo_idx])
        T_PUSH:  ras_pop_en = 1'b1;
        T_POP: begin
          ras_push_en   = 1'b1;
          ras_push_data = dat_q[undo_idx];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    count_post = count_q - CW'(commit_ok);
    if (!stall) begin
      if (idle) begin
        head_d  = head_q + AW'(commit_ok);
        tail_d  = tail_q + AW'(accept);
        count_d = count_post + CW'(accept);
        if (flush && count_post != '0) state_d = S_REPAIR;
      end else begin
        tail_d  = undo_idx;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      typ_q[tail_q] <= wr_typ;
      dat_q[tail_q] <= wr_dat;
    end
  end

endmodule

// File: tb/tb_ras_spec_ctrl.sv
// Bench for ras_spec_ctrl: directed test-plan steps then random traffic, checked
// against a queue-based undo-log model and a behavioural RAS.
module tb_ras_spec_ctrl;
  localparam int XLEN = 32;
  localparam int LD   = 8;
  localparam int CW   = $clog2(LD) + 1;

  typedef enum int {E_NOP, E_PUSH, E_POP, E_BOTH} etyp_t;
  typedef struct {
    etyp_t           t;
    logic [XLEN-1:0] d;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0, stall = 1'b0;
  logic            pred_valid = 1'b0, pred_call = 1'b0, pred_ret = 1'b0;
  logic [XLEN-1:0] pred_ra = '0;
  logic            commit_valid = 1'b0, flush = 1'b0;
  logic [XLEN-1:0] ras_peek_data = '0;
  logic            ras_empty = 1'b1;
  logic            pred_ready, pred_target_valid, busy;
  logic            ras_push_en, ras_pop_en, ras_stall;
  logic [XLEN-1:0] pred_target, ras_push_data;
  logic [CW-1:0]   log_count;

  ras_spec_ctrl #(.DEPTH(16), .LOG_DEPTH(LD), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .pred_valid(pred_valid), .pred_call(pred_call), .pred_ret(pred_ret), .pred_ra(pred_ra),
    .pred_ready(pred_ready), .pred_target(pred_target), .pred_target_valid(pred_target_valid),
    .commit_valid(commit_valid), .flush(flush), .busy(busy), .log_count(log_count),
    .ras_push_en(ras_push_en), .ras_push_data(ras_push_data), .ras_pop_en(ras_pop_en),
    .ras_stall(ras_stall), .ras_peek_data(ras_peek_data), .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  int              checks = 0, errors = 0;
  ent_t            logq[$];      // live speculative ops, oldest first
  logic [XLEN-1:0] mstk[$];      // stack contents the controller should produce
  logic [XLEN-1:0] env[$];       // behavioural RAS driven by the DUT
  bit              repairing = 1'b0;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic env_apply(input logic pu, input logic po, input logic [XLEN-1:0] d);
    if (pu && !po) env.push_back(d);
    else if (po && !pu && env.size() > 0) env.delete(env.size() - 1);
    ras_empty     = (env.size() == 0);
    ras_peek_data = ras_empty ? '0 : env[env.size() - 1];
  endtask

  task automatic step(input logic v, input logic c, input logic r, input logic [XLEN-1:0] ra,
                      input logic cm, input logic fl, input logic st);
    logic ep, eo, er, apu, apo;
    logic [XLEN-1:0] ed, ad;
    ent_t e, ne;
    bit acc;
    @(negedge clk);
    rst = 1'b1; pred_valid = v; pred_call = c; pred_ret = r; pred_ra = ra;
    commit_valid = cm; flush = fl; stall = st;
    #1;
    ep = 0; eo = 0; er = 0; ed = '0; acc = 0; ne.t = E_NOP; ne.d = '0;
    if (!st) begin
      if (!repairing) begin
        er  = !fl && logq.size() < LD;
        acc = v && er;
        if (acc) begin
          if (c) begin
            ep = 1; eo = r; ed = ra;
            ne.t = r ? E_BOTH : E_PUSH; ne.d = ra;
          end else if (r && mstk.size() > 0) begin
            eo = 1; ne.t = E_POP; ne.d = mstk[$];
          end
        end
      end else begin
        e = logq[$];
        if (e.t == E_PUSH) eo = 1;
        else if (e.t == E_POP) begin ep = 1; ed = e.d; end
      end
    end
    chk("pred_ready", pred_ready, er);
    chk("push_en", ras_push_en, ep);
    chk("pop_en", ras_pop_en, eo);
    if (ep) chk("push_data", ras_push_data, ed);
    chk("ras_stall", ras_stall, st);
    chk("busy", busy, repairing);
    chk("log_count", log_count, logq.size());
    chk("ras_state_empty", ras_empty, mstk.size() == 0);
    if (mstk.size() > 0) chk("pred_target", pred_target, mstk[$]);
    chk("target_valid", pred_target_valid, mstk.size() > 0 && !repairing);
    apu = ras_push_en; apo = ras_pop_en; ad = ras_push_data;
    @(posedge clk);
    if (!st) begin
      if (!repairing) begin
        if (cm && logq.size() > 0) logq.delete(0);
        if (acc) logq.push_back(ne);
        if (fl && logq.size() > 0) repairing = 1'b1;
      end else begin
        logq.delete(logq.size() - 1);
        if (logq.size() == 0) repairing = 1'b0;
      end
      if (ep && !eo) mstk.push_back(ed);
      else if (eo && !ep && mstk.size() > 0) mstk.delete(mstk.size() - 1);
    end
    #1 env_apply(apu, apo, ad);
  endtask

  task automatic idle_step();
    step(0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; pred_valid = 0; pred_call = 0; pred_ret = 0; commit_valid = 0; flush = 0; stall = 0;
    #1;
    chk("rst_ras_stall", ras_stall, 1);
    chk("rst_push_en", ras_push_en, 0);
    chk("rst_pop_en", ras_pop_en, 0);
    chk("rst_push_data", ras_push_data, 0);
    chk("rst_ready", pred_ready, 0);
    @(posedge clk);
    logq.delete();
    repairing = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_count", log_count, 0);
  endtask

  initial begin
    do_reset();

    // push then pop
    step(1, 1, 0, 32'h1000, 0, 0, 0);
    step(1, 1, 0, 32'h2000, 0, 0, 0);
    chk("t1_target_2000", pred_target, 32'h2000);
    step(1, 0, 1, '0, 0, 0, 0);
    chk("t1_target_1000", pred_target, 32'h1000);
    chk("t1_count3", log_count, 3);

    // flush undoes all three
    step(0, 0, 0, '0, 0, 1, 0);
    repeat (3) idle_step();
    chk("t2_empty", ras_empty, 1);
    chk("t2_busy", busy, 0);
    chk("t2_count", log_count, 0);

    // commit then flush
    step(1, 1, 0, 32'hA0, 0, 0, 0);
    step(1, 1, 0, 32'hB0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    step(0, 0, 0, '0, 0, 1, 0);
    idle_step();
    chk("t3_target", pred_target, 32'hA0);
    chk("t3_busy", busy, 0);

    // full log
    for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h100 + 32'(i * 16), 0, 0, 0);
    chk("t4_full", log_count, 8);
    step(1, 1, 0, 32'hDEAD, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    step(1, 1, 0, 32'h900, 1, 0, 0);
    chk("t4_commit_accept", log_count, 7);
    step(1, 1, 0, 32'h910, 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, 0);
    repeat (8) idle_step();
    chk("t4_busy", busy, 0);

    // empty-ret and BOTH
    for (int i = 0; i < 16 && mstk.size() > 0; i++) begin
      step(1, 0, 1, '0, 0, 0, 0);
      step(0, 0, 0, '0, 1, 0, 0);
    end
    step(1, 0, 1, '0, 0, 0, 0);
    step(1, 1, 1, 32'h55, 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, 0);
    chk("t5_busy1", busy, 1);
    idle_step();
    chk("t5_busy2", busy, 1);
    idle_step();
    chk("t5_done", busy, 0);
    chk("t5_empty", ras_empty, 1);

    // stall mid-repair
    for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h3000 + 32'(i), 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, 0);
    idle_step();
    repeat (3) step(1, 1, 0, 32'hBAD, 1, 1, 1);
    chk("t6_count_held", log_count, 3);
    repeat (3) idle_step();
    chk("t6_busy", busy, 0);

    // reset mid-repair
    for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h4000 + 32'(i), 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, 0);
    idle_step();
    do_reset();
    idle_step();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(199) == 0) do_reset();
      else step($urandom_range(99) < 70, 1'($urandom_range(1)), 1'($urandom_range(1)),
                XLEN'($urandom), $urandom_range(99) < 25, $urandom_range(99) < 5,
                $urandom_range(99) < 10);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
